// File: rtl/camellia_pkg.sv
// Shared definitions for the camellia core and its block packer: widths,
// packer state encoding, key-size codes and a block slot helper.
package camellia_pkg;

   localparam int CAM_BLOCK_W = 128;
   localparam int CAM_WORD_W  = 32;
   localparam int CAM_WORDS   = CAM_BLOCK_W / CAM_WORD_W;

   typedef enum logic {
      PK_FILL    = 1'b0,
      PK_PRESENT = 1'b1
   } pk_state_e;

   // Key-size codes understood by the core's i_key_size input.
   localparam logic [1:0] CAM_KEY128 = 2'b00;
   localparam logic [1:0] CAM_KEY192 = 2'b01;
   localparam logic [1:0] CAM_KEY256 = 2'b10;

   // Slot 0 is the most significant word of the block.
   function automatic logic [CAM_BLOCK_W-1:0] put_word(
      input logic [CAM_BLOCK_W-1:0] blk,
      input logic [1:0]             idx,
      input logic [CAM_WORD_W-1:0]  word
   );
      logic [CAM_BLOCK_W-1:0] r;
      r = blk;
      r[(CAM_BLOCK_W - 1) - (int'(idx) * CAM_WORD_W) -: CAM_WORD_W] = word;
      return r;
   endfunction

endpackage

// File: rtl/camellia_block_packer.sv
// Packs a 32-bit word stream into 128-bit blocks for the camellia core,
// padding a short final block with PAD_WORD.
module camellia_block_packer
   import camellia_pkg::*;
#(
   parameter int                WORD_W   = CAM_WORD_W,
   parameter int                BLOCK_W  = CAM_BLOCK_W,
   parameter logic [WORD_W-1:0] PAD_WORD = '0
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_wvalid,
   output logic               o_wready,
   input  logic [WORD_W-1:0]  i_wdata,
   input  logic               i_wlast,
   input  logic               i_encrypt,
   output logic               o_pvalid,
   input  logic               i_pready,
   output logic [BLOCK_W-1:0] o_plaintext,
   output logic               o_encrypt,
   output logic               o_padded,
   output logic               o_last,
   output pk_state_e          o_state
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are
   // both high; a valid source holds its payload stable until that edge, and
   // ready never depends combinationally on valid.

   pk_state_e          state_q, state_d;
   logic [1:0]         count_q, count_d;
   logic [BLOCK_W-1:0] block_q, block_d;
   logic               enc_q, enc_d;
   logic               pad_q, pad_d;
   logic               last_q, last_d;
   logic               rdy_q;
   logic               accept;
   logic               xfer;

   // rdy_q keeps o_wready low through reset and the edge that releases it.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
      end
   end

   assign accept = rdy_q && (state_q == PK_FILL) && i_wvalid;
   assign xfer   = (state_q == PK_PRESENT) && i_pready;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= PK_FILL;
         count_q <= 2'd0;
         block_q <= '0;
         enc_q   <= 1'b0;
         pad_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         block_q <= block_d;
         enc_q   <= enc_d;
         pad_q   <= pad_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      block_d = block_q;
      enc_d   = enc_q;
      pad_d   = pad_q;
      last_d  = last_q;
      case (state_q)
         PK_FILL: begin
            if (accept) begin
               block_d = put_word(block_q, count_q, i_wdata);
               if (count_q == 2'd0) begin
                  enc_d = i_encrypt;
               end
               if (count_q == 2'd3) begin
                  state_d = PK_PRESENT;
                  pad_d   = 1'b0;
                  last_d  = i_wlast;
               end else if (i_wlast) begin
                  // Short final block: every slot after the last data word gets fill.
                  for (int i = 1; i < CAM_WORDS; i++) begin
                     if (2'(i) > count_q) begin
                        block_d = put_word(block_d, 2'(i), PAD_WORD);
                     end
                  end
                  state_d = PK_PRESENT;
                  pad_d   = 1'b1;
                  last_d  = 1'b1;
               end else begin
                  count_d = count_q + 2'd1;
               end
            end
         end
         PK_PRESENT: begin
            if (xfer) begin
               state_d = PK_FILL;
               count_d = 2'd0;
               pad_d   = 1'b0;
               last_d  = 1'b0;
            end
         end
         default: begin
            state_d = PK_FILL;
            count_d = 2'd0;
         end
      endcase
   end

   assign o_wready    = rdy_q && (state_q == PK_FILL);
   assign o_pvalid    = (state_q == PK_PRESENT);
   assign o_plaintext = block_q;
   assign o_encrypt   = enc_q;
   assign o_padded    = pad_q;
   assign o_last      = last_q;
   assign o_state     = state_q;

endmodule
